// File: rtl/seg_scan_pkg.sv
// ----------------------------------------------------------------------------
// seg_scan_pkg
//   Shared types and helpers for the multiplexed 7-segment scan controller.
//   - scan_state_t : scan FSM states (blank gap / digit shown)
//   - BLANK_CODE   : decoder input code that turns every segment off
//   - hex_to_code  : hex nibble -> 6-bit decoder input code
// ----------------------------------------------------------------------------
package seg_scan_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_t;

    localparam logic [5:0] BLANK_CODE = 6'b111111;

    // 0..9 pass through as {00, v}; A..F become {01, v-10}.
    function automatic logic [5:0] hex_to_code(input logic [3:0] v);
        if (v < 4'd10) return {2'b00, v};
        else           return {2'b01, v - 4'd10};
    endfunction

endpackage

// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexes one shared 7-segment decoder across N_DIGITS digits.
//   Each digit is driven for DWELL cycles, separated by BLANK_CYC cycles with
//   every digit off. New frames arrive via a valid/ready handshake into a
//   pending buffer and are copied to the displayed frame only at a frame
//   boundary (blank gap exiting into digit 0), so a frame never tears.
//
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     enable       : scanning enabled; low forces a blank restart
//     load_valid   : new frame offered on load_digits
//     load_ready   : pending buffer empty, a frame can be accepted
//     load_digits  : 4 bits per digit, digit 0 in bits [3:0] (rightmost)
//     bcd_code     : code to the shared decoder input
//     dig_en_n     : active-low digit enables (one low, or all high)
//     frame_done   : one-cycle pulse after each frame boundary
//
//   Build option:
//     SEG_LEADING_ZERO_BLANK_EN - when defined, leading zero digits (from the
//     top digit downward, never digit 0) are shown blank; slot timing is kept.
// ----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int DWELL     = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*N_DIGITS-1:0] load_digits,
    output logic [5:0]            bcd_code,
    output logic [N_DIGITS-1:0]   dig_en_n,
    output logic                  frame_done
);

    localparam int CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    scan_state_t                 state_q,    state_d;
    logic [IDX_W-1:0]            idx_q,      idx_d;
    logic [CNT_W-1:0]            cnt_q,      cnt_d;
    logic [N_DIGITS-1:0][3:0]    active_q,   active_d;
    logic [N_DIGITS-1:0][3:0]    pending_q,  pending_d;
    logic                        pend_vld_q, pend_vld_d;
    logic [N_DIGITS-1:0]         dig_en_n_q, dig_en_n_d;
    logic [5:0]                  bcd_q,      bcd_d;
    logic                        frame_done_q, frame_done_d;
    logic                        boundary;
    logic [N_DIGITS-1:0]         sup;

    // ------------------------------------------------------------------
    // Scan sequencing and frame buffers
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        boundary   = 1'b0;

        if (!enable) begin
            // Held in reset-like blank; every idle cycle acts as a boundary
            // for the frame buffer, without a frame_done pulse.
            state_d = S_BLANK;
            idx_d   = '0;
            cnt_d   = '0;
            if (pend_vld_q) begin
                active_d   = pending_q;
                pend_vld_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d  = S_SHOW;
                        cnt_d    = '0;
                        boundary = (idx_q == '0);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_BLANK;
            endcase

            if (boundary && pend_vld_q) begin
                active_d   = pending_q;
                pend_vld_d = 1'b0;
            end
        end

        // load_ready is !pend_vld_q, so a transfer never collides with the
        // pending->active copy above; a load on the boundary edge waits a frame.
        if (load_valid && !pend_vld_q) begin
            pending_d  = load_digits;
            pend_vld_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression, evaluated on the frame about to be shown
    // ------------------------------------------------------------------
`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic seen_nz;
        seen_nz = 1'b0;
        sup     = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (active_d[i] != 4'd0) seen_nz = 1'b1;
            sup[i] = !seen_nz;
        end
    end
`else
    assign sup = '0;
`endif

    // ------------------------------------------------------------------
    // Registered outputs follow the next state so they switch on the same
    // edge as the FSM.
    // ------------------------------------------------------------------
    always_comb begin
        dig_en_n_d   = '1;
        bcd_d        = BLANK_CODE;
        frame_done_d = boundary;
        if (state_d == S_SHOW && !sup[idx_d]) begin
            dig_en_n_d[idx_d] = 1'b0;
            bcd_d             = hex_to_code(active_d[idx_d]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_BLANK;
            idx_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_vld_q   <= 1'b0;
            dig_en_n_q   <= '1;
            bcd_q        <= BLANK_CODE;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_vld_q   <= pend_vld_d;
            dig_en_n_q   <= dig_en_n_d;
            bcd_q        <= bcd_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready = !pend_vld_q;
    assign dig_en_n   = dig_en_n_q;
    assign bcd_code   = bcd_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (N_DIGITS=4, DWELL=3, BLANK_CYC=1). Expected digit
// slots are queued as frames are loaded; a monitor pops one entry each time a
// digit slot starts. Honours SEG_LEADING_ZERO_BLANK_EN when it is defined.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int DW = 3;
    localparam int BC = 1;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] SUP_ZERO = 4'b1110;
    localparam logic [3:0] SUP_0050 = 4'b1100;
    localparam int         NZ_0050  = 6;
`else
    localparam logic [3:0] SUP_ZERO = 4'b0000;
    localparam logic [3:0] SUP_0050 = 4'b0000;
    localparam int         NZ_0050  = 12;
`endif

    typedef struct {
        logic [3:0] en;
        logic [5:0] code;
        int         gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_digits = '0;
    logic [5:0]  bcd_code;
    logic [3:0]  dig_en_n;
    logic        frame_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    int   skipped = 0;
    bit   mon_en = 1'b0;

    seg_scan_ctrl #(.N_DIGITS(ND), .DWELL(DW), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .load_valid(load_valid), .load_ready(load_ready), .load_digits(load_digits),
        .bcd_code(bcd_code), .dig_en_n(dig_en_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Queue one frame of expected slots; codes[i] is the code for digit i.
    // gap = blank cycles expected before the slot (suppressed slots widen it).
    task automatic push_frame(input logic [3:0][5:0] codes, input logic [3:0] sup);
        exp_t e;
        for (int i = 0; i < ND; i++) begin
            if (sup[i]) begin
                skipped++;
            end else begin
                e.en   = ~(4'b0001 << i);
                e.code = codes[i];
                e.gap  = BC + skipped * (DW + BC);
                exp_q.push_back(e);
                skipped = 0;
            end
        end
    endtask

    task automatic flush_exp();
        exp_q.delete();
        skipped = 0;
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin ok = 1'b1; return; end
        end
    endtask

    task automatic wait_en(input logic [3:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (dig_en_n === v) begin ok = 1'b1; return; end
        end
    endtask

    // Slot monitor: samples 1 time unit after each rising edge.
    logic [3:0] m_prev = 4'hF;
    int         m_run = 0, m_blank = 0;
    bit         m_seen = 1'b0;
    exp_t       m_e;
    always @(posedge clk) begin
        #1;
        if (!mon_en) begin
            m_prev = 4'hF; m_run = 0; m_blank = 0; m_seen = 1'b0;
        end else begin
            if (m_prev !== 4'hF && dig_en_n !== m_prev) begin
                n_checks++;
                if (m_run != DW) begin
                    n_fail++;
                    $display("FAIL slot_len: digit %b driven %0d cycles, required %0d", m_prev, m_run, DW);
                end
            end
            if (dig_en_n === 4'hF) begin
                m_blank++;
                n_checks++;
                if (bcd_code !== 6'b111111) begin
                    n_fail++;
                    $display("FAIL blank_code: bcd_code=%b during blank, required 111111", bcd_code);
                end
            end else if (dig_en_n !== m_prev) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL slot_unexpected: dig_en_n=%b bcd_code=%b with nothing expected", dig_en_n, bcd_code);
                end else begin
                    m_e = exp_q.pop_front();
                    if (dig_en_n !== m_e.en || bcd_code !== m_e.code) begin
                        n_fail++;
                        $display("FAIL slot: dig_en_n=%b bcd_code=%b, required %b %b", dig_en_n, bcd_code, m_e.en, m_e.code);
                    end
                    if (m_seen) begin
                        n_checks++;
                        if (m_blank != m_e.gap) begin
                            n_fail++;
                            $display("FAIL blank_len: %0d blank cycles before %b, required %0d", m_blank, dig_en_n, m_e.gap);
                        end
                    end
                end
                m_run = 1; m_blank = 0; m_seen = 1'b1;
            end else begin
                m_run++;
            end
            m_prev = dig_en_n;
        end
    end

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; load_valid = 1'b0; load_digits = '0;
        @(negedge clk);
        n_checks += 4;
        if (dig_en_n !== 4'hF) begin n_fail++; $display("FAIL reset_dig_en_n: got %b, required 1111", dig_en_n); end
        if (bcd_code !== 6'b111111) begin n_fail++; $display("FAIL reset_bcd: got %b, required 111111", bcd_code); end
        if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", load_ready); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_frame();
        int cyc;
        @(negedge clk);
        push_frame({6'b000000, 6'b000000, 6'b000000, 6'b000000}, SUP_ZERO);
        push_frame({6'b000011, 6'b000010, 6'b000001, 6'b000000}, 4'b0000);
        mon_en = 1'b1; enable = 1'b1; load_valid = 1'b1; load_digits = 16'h3210;
        @(negedge clk);
        n_checks += 2;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL first_boundary: frame_done=%b, required 1", frame_done); end
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL first_pending: load_ready=%b, required 0", load_ready); end
        load_valid = 1'b0;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (frame_done === 1'b1) break;
        end
        n_checks += 2;
        if (cyc != 16) begin n_fail++; $display("FAIL frame_period: got %0d cycles, required 16", cyc); end
        if (load_ready !== 1'b1) begin n_fail++; $display("FAIL applied_ready: load_ready=%b, required 1", load_ready); end
    endtask

    task automatic test_hex_letters();
        bit ok;
        push_frame({6'b010101, 6'b010000, 6'b001001, 6'b000100}, 4'b0000);
        load_valid = 1'b1; load_digits = 16'hFA94;
        @(negedge clk);
        load_valid = 1'b0;
        wait_fd(ok);
        n_checks += 4;
        if (!ok) begin n_fail++; $display("FAIL hex_timeout: no frame_done, required one within 64 cycles"); end
        if (load_ready !== 1'b1) begin n_fail++; $display("FAIL hex_ready: load_ready=%b, required 1", load_ready); end
        if (dig_en_n !== 4'b1110) begin n_fail++; $display("FAIL hex_d0_en: got %b, required 1110", dig_en_n); end
        if (bcd_code !== 6'b000100) begin n_fail++; $display("FAIL hex_d0_code: got %b, required 000100", bcd_code); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        push_frame({6'b000001, 6'b000011, 6'b000101, 6'b000111}, 4'b0000);
        push_frame({6'b000010, 6'b000100, 6'b000110, 6'b001000}, 4'b0000);
        load_valid = 1'b1; load_digits = 16'h1357;
        @(negedge clk);
        load_digits = 16'h2468;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (frame_done === 1'b1) begin ok = 1'b1; break; end
            n_checks++;
            if (load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_hold: load_ready=%b before boundary, required 0", load_ready); end
            @(negedge clk);
        end
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL b2b_timeout: no frame_done, required one within 40 cycles"); end
        if (load_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_release: load_ready=%b after boundary, required 1", load_ready); end
        @(negedge clk);
        load_valid = 1'b0;
        n_checks++;
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second: load_ready=%b, required 0", load_ready); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        wait_fd(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drop_fd_timeout: no frame_done, required one"); end
        load_valid = 1'b1; load_digits = 16'hC0DE;
        @(negedge clk);
        load_valid = 1'b0;
        wait_en(4'b1011, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drop_d2_timeout: digit 2 never shown, required within 64 cycles"); end
        mon_en = 1'b0; enable = 1'b0;
        flush_exp();
        @(negedge clk);
        n_checks += 4;
        if (dig_en_n !== 4'hF) begin n_fail++; $display("FAIL drop_en: got %b, required 1111", dig_en_n); end
        if (bcd_code !== 6'b111111) begin n_fail++; $display("FAIL drop_bcd: got %b, required 111111", bcd_code); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL drop_fd: got %b, required 0", frame_done); end
        if (load_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready: got %b, required 1", load_ready); end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (dig_en_n !== 4'hF) begin n_fail++; $display("FAIL drop_hold: got %b, required 1111", dig_en_n); end
        end
        push_frame({6'b010010, 6'b000000, 6'b010011, 6'b010100}, 4'b0000);
        mon_en = 1'b1; enable = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (dig_en_n !== 4'b1110) begin n_fail++; $display("FAIL reen_en: got %b, required 1110", dig_en_n); end
        if (bcd_code !== 6'b010100) begin n_fail++; $display("FAIL reen_code: got %b, required 010100", bcd_code); end
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL reen_fd: got %b, required 1", frame_done); end
    endtask

    task automatic test_async_reset();
        bit ok;
        wait_en(4'b1101, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL arst_d1_timeout: digit 1 never shown, required within 64 cycles"); end
        mon_en = 1'b0;
        flush_exp();
        load_valid = 1'b1; load_digits = 16'h9999;
        @(posedge clk);
        #2;
        n_checks += 2;
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL arst_pre_ready: got %b, required 0", load_ready); end
        if (dig_en_n !== 4'b1101) begin n_fail++; $display("FAIL arst_pre_en: got %b, required 1101", dig_en_n); end
        rst = 1'b1;
        #1;
        n_checks += 4;
        if (dig_en_n !== 4'hF) begin n_fail++; $display("FAIL arst_en: got %b, required 1111", dig_en_n); end
        if (bcd_code !== 6'b111111) begin n_fail++; $display("FAIL arst_bcd: got %b, required 111111", bcd_code); end
        if (load_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b, required 1", load_ready); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL arst_fd: got %b, required 0", frame_done); end
        load_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // Pending 9999 must be gone: two all-zero frames follow.
        push_frame({6'b000000, 6'b000000, 6'b000000, 6'b000000}, SUP_ZERO);
        push_frame({6'b000000, 6'b000000, 6'b000000, 6'b000000}, SUP_ZERO);
        mon_en = 1'b1;
        repeat (2) begin
            wait_fd(ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL arst_fd_timeout: no frame_done, required one"); end
        end
    endtask

    task automatic test_leading_zero();
        bit ok;
        int nz;
        push_frame({6'b000000, 6'b000000, 6'b000101, 6'b000000}, SUP_0050);
        load_valid = 1'b1; load_digits = 16'h0050;
        @(negedge clk);
        load_valid = 1'b0;
        wait_fd(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL lz_timeout: no frame_done, required one"); end
        nz = 0;
        for (int i = 0; i < 16; i++) begin
            if (dig_en_n !== 4'hF) nz++;
            if (i < 15) @(negedge clk);
        end
        mon_en = 1'b0;
        n_checks += 2;
        if (nz != NZ_0050) begin n_fail++; $display("FAIL lz_lit_cycles: %0d lit cycles in frame, required %0d", nz, NZ_0050); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL lz_drain: %0d expected slots unseen, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_hex_letters();
        test_back_to_back();
        test_enable_drop();
        test_async_reset();
        test_leading_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
